// File: rtl/wrd_pkg.sv
// Shared definitions for the wake-word datapath: element width and the
// two-state fill/drain control encoding used by the frame transposer.
package wrd_pkg;

  localparam int BW = 8;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/transpose_mem.sv
// Frame buffer for the transposer: FRAME_LEN x NUM_FILTERS elements.
// One element is written per cycle at (wr_t, wr_f); the read port returns a
// whole time row combinationally, packed with filter f at [f*BW +: BW].
module transpose_mem
  import wrd_pkg::*;
#(
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = 8,
  parameter int TW          = 6,
  parameter int FW          = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we,
  input  logic [TW-1:0]             wr_t,
  input  logic [FW-1:0]             wr_f,
  input  logic [BW-1:0]             wr_data,
  input  logic [TW-1:0]             rd_t,
  output logic [NUM_FILTERS*BW-1:0] rd_row
);

  logic [BW-1:0] mem_reg [FRAME_LEN][NUM_FILTERS];

  // Element storage; cleared on reset so an idle read row is all zeros.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int t = 0; t < FRAME_LEN; t++) begin
        for (int f = 0; f < NUM_FILTERS; f++) begin
          mem_reg[t][f] <= '0;
        end
      end
    end else if (we) begin
      mem_reg[wr_t][wr_f] <= wr_data;
    end
  end

  // Row read: one mux lane per filter, all sharing the time index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FILTERS; gi++) begin : g_row
      assign rd_row[gi*BW +: BW] = mem_reg[rd_t][gi];
    end
  endgenerate

endmodule

// File: rtl/frame_transposer.sv
// Converts the filter-major conv output stream into time-major vectors.
// A whole frame is captured in FILL, then replayed one time row per
// handshake in DRAIN. Outputs depend only on registered state.
module frame_transposer
  import wrd_pkg::*;
#(
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [BW-1:0]             data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      ready_o,
  output logic [NUM_FILTERS*BW-1:0] data_o,
  output logic                      valid_o,
  output logic                      last_o,
  input  logic                      ready_i,
  output logic                      err_o
);

  localparam int TW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] F_LAST = FW'(NUM_FILTERS - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] in_t_reg, in_t_next;
  logic [FW-1:0] in_f_reg, in_f_next;
  logic [TW-1:0] out_t_reg, out_t_next;
  logic          ready_reg, ready_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;

  logic accept;
  logic final_beat;
  logic out_hs;

  // ready_reg is only ever high in FILL, so it alone qualifies acceptance.
  assign accept     = valid_i && ready_reg;
  assign final_beat = (in_t_reg == T_LAST) && (in_f_reg == F_LAST);
  assign out_hs     = valid_reg && ready_i;

  // Next-state, counter and error-pulse logic.
  always_comb begin
    state_next = state_reg;
    in_t_next  = in_t_reg;
    in_f_next  = in_f_reg;
    out_t_next = out_t_reg;
    err_next   = 1'b0;
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (final_beat) begin
            // Frame complete; a missing last is flagged but tolerated.
            in_t_next  = '0;
            in_f_next  = '0;
            state_next = DRAIN;
            err_next   = !last_i;
          end else if (last_i) begin
            // Early last: drop the partial frame and start over.
            in_t_next = '0;
            in_f_next = '0;
            err_next  = 1'b1;
          end else if (in_t_reg == T_LAST) begin
            in_t_next = '0;
            in_f_next = in_f_reg + FW'(1);
          end else begin
            in_t_next = in_t_reg + TW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (out_t_reg == T_LAST) begin
            out_t_next = '0;
            state_next = FILL;
          end else begin
            out_t_next = out_t_reg + TW'(1);
          end
        end
      end
      default: state_next = FILL;
    endcase
    ready_next = (state_next == FILL);
    valid_next = (state_next == DRAIN);
  end

  // State and counter registers; ready stays low for the first cycle out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= FILL;
      in_t_reg  <= '0;
      in_f_reg  <= '0;
      out_t_reg <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      in_t_reg  <= in_t_next;
      in_f_reg  <= in_f_next;
      out_t_reg <= out_t_next;
      ready_reg <= ready_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  transpose_mem #(
    .FRAME_LEN  (FRAME_LEN),
    .NUM_FILTERS(NUM_FILTERS),
    .TW         (TW),
    .FW         (FW)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we     (accept),
    .wr_t   (in_t_reg),
    .wr_f   (in_f_reg),
    .wr_data(data_i),
    .rd_t   (out_t_reg),
    .rd_row (data_o)
  );

  assign ready_o = ready_reg;
  assign valid_o = valid_reg;
  assign last_o  = valid_reg && (out_t_reg == T_LAST);
  assign err_o   = err_reg;

endmodule
